// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous VRAM between the display
// scan-out fetch (priority) and the CPU bus. A starvation counter forces a CPU
// slot after CPU_WAIT_MAX consecutive denied cycles (0 disables forcing).
// Both requesters see a fixed 3-cycle latency from grant to result.
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CPU_WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (CPU_WAIT_MAX > 0) ? $clog2(CPU_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(CPU_WAIT_MAX);

    typedef enum logic [2:0] {
        C_IDLE,
        C_WAIT,
        C_MEM,
        C_RD,
        C_ACK
    } cpu_state_t;

    cpu_state_t        r_state;
    cpu_state_t        w_state_next;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_cpu_is_rd;
    logic              r_dv1;
    logic              r_dv2;
    logic              r_disp_valid;
    logic              r_disp_miss;
    logic [DATA_W-1:0] r_disp_data;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [1:0]        r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_cpu_elig;
    logic w_force;
    logic w_cpu_gnt;
    logic w_disp_gnt;

    // Grant decision and CPU FSM next state.
    always_comb begin
        w_cpu_elig   = ((r_state == C_IDLE) || (r_state == C_WAIT)) && cpu_req;
        w_force      = (CPU_WAIT_MAX != 0) && (r_starve_cnt == WAIT_MAX_C);
        w_cpu_gnt    = w_cpu_elig && (!disp_req || w_force);
        w_disp_gnt   = disp_req && !w_cpu_gnt;
        w_state_next = r_state;
        case (r_state)
            C_IDLE:  if (w_cpu_gnt) w_state_next = C_MEM;
                     else if (cpu_req) w_state_next = C_WAIT;
            // A dropped request (protocol violation) returns to idle rather than hang.
            C_WAIT:  if (w_cpu_gnt) w_state_next = C_MEM;
                     else if (!cpu_req) w_state_next = C_IDLE;
            C_MEM:   w_state_next = C_RD;
            C_RD:    w_state_next = C_ACK;
            C_ACK:   w_state_next = C_IDLE;
            default: w_state_next = C_IDLE;
        endcase
    end

    // CPU FSM state, starvation counter and CPU read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= C_IDLE;
            r_starve_cnt <= '0;
            r_cpu_is_rd  <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cpu_gnt) begin
                r_starve_cnt <= '0;
                r_cpu_is_rd  <= !cpu_we;
            end else if (w_cpu_elig && (r_starve_cnt != WAIT_MAX_C)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if ((r_state == C_RD) && r_cpu_is_rd) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    // VRAM access registers; address/enables hold when nobody is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 2'b00;
            r_mem_wdata <= '0;
        end else if (w_cpu_gnt) begin
            r_mem_addr  <= cpu_addr;
            r_mem_we    <= cpu_we;
            r_mem_be    <= cpu_we ? cpu_be : 2'b11;
            r_mem_wdata <= cpu_wdata;
        end else if (w_disp_gnt) begin
            r_mem_addr <= disp_addr;
            r_mem_we   <= 1'b0;
            r_mem_be   <= 2'b11;
        end else begin
            r_mem_we <= 1'b0;
        end
    end

    // Display return pipeline: grant -> mem cycle -> rdata -> registered pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dv1        <= 1'b0;
            r_dv2        <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_miss  <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_dv1        <= w_disp_gnt;
            r_dv2        <= r_dv1;
            r_disp_valid <= r_dv2;
            r_disp_miss  <= w_cpu_gnt && disp_req;
            if (r_dv2) begin
                r_disp_data <= mem_rdata;
            end
        end
    end

    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign disp_miss  = r_disp_miss;
    assign cpu_ack    = (r_state == C_ACK);
    assign cpu_rdata  = r_cpu_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance with CPU_WAIT_MAX=8, one with 0,
// each attached to its own behavioural read-first synchronous VRAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req, disp_req0;
    logic [15:0] disp_addr;
    logic        cpu_req, cpu_req0, cpu_we;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_addr, cpu_wdata;

    logic [15:0] disp_data, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        disp_valid, disp_miss, cpu_ack, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] disp_data0, cpu_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        disp_valid0, disp_miss0, cpu_ack0, mem_we0;
    logic [1:0]  mem_be0;

    logic [15:0] ram  [0:65535];
    logic [15:0] ram0 [0:65535];

    int tests = 0;
    int fails = 0;
    int lat, miss_cnt, miss_at, we_cnt, acks;
    logic [1:0]  be_seen;
    logic [15:0] addr_seen, wd_seen;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_WAIT_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .disp_miss(disp_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    vram_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_WAIT_MAX(0)) dut0 (
        .clk(clk), .rst(rst),
        .disp_req(disp_req0), .disp_addr(disp_addr), .disp_data(disp_data0),
        .disp_valid(disp_valid0), .disp_miss(disp_miss0),
        .cpu_req(cpu_req0), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
        .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_be(mem_be0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 37) ^ 16'hC35A;
    endfunction

    // Read-first synchronous VRAM models with byte enables.
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
            if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
        end
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we0) begin
            if (mem_be0[1]) ram0[mem_addr0][15:8] <= mem_wdata0[15:8];
            if (mem_be0[0]) ram0[mem_addr0][7:0]  <= mem_wdata0[7:0];
        end
        mem_rdata0 <= ram0[mem_addr0];
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = pat(i);
            ram0[i] = pat(i);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_disp_data"}, disp_data, 0);
        chk({tag, "_disp_valid"}, disp_valid, 0);
        chk({tag, "_disp_miss"}, disp_miss, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Issue one CPU transaction on dut in the current cycle and wait for its ack.
    task automatic cpu_txn(input logic we, input logic [1:0] be, input logic [15:0] addr,
                           input logic [15:0] wd, input int exp_lat, input logic chk_rd,
                           input logic [15:0] exp_rd, input string tag);
        cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        lat = 0; miss_cnt = 0; miss_at = -1; we_cnt = 0;
        while (cpu_ack !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (disp_miss) begin
                miss_cnt++;
                miss_at = lat;
            end
            if (mem_we) begin
                we_cnt++;
                be_seen = mem_be; addr_seen = mem_addr; wd_seen = mem_wdata;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        if (chk_rd) chk({tag, "_rdata"}, cpu_rdata, exp_rd);
        cpu_req = 1'b0;
        tick();
        chk({tag, "_ack_one_cycle"}, cpu_ack, 0);
    endtask

    initial begin
        disp_req = 0; disp_req0 = 0; disp_addr = 0;
        cpu_req = 0; cpu_req0 = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
        rst = 1'b1;
        tick(); tick();
        chk_zero("reset");
        chk("reset_ack0", cpu_ack0, 0);
        rst = 1'b0;
        tick();

        // CPU write then read, display idle.
        cpu_txn(1'b1, 2'b11, 16'h0100, 16'h1234, 3, 1'b0, 16'h0, "wr");
        chk("wr_we_cycles", we_cnt, 1);
        chk("wr_addr", addr_seen, 16'h0100);
        chk("wr_be", be_seen, 2'b11);
        chk("wr_wdata", wd_seen, 16'h1234);
        chk("wr_rdata_unchanged", cpu_rdata, 16'h0000);
        cpu_txn(1'b0, 2'b00, 16'h0100, 16'h0000, 3, 1'b1, 16'h1234, "rd");
        chk("rd_we_cycles", we_cnt, 0);

        // Display streams 0x00..0xEF every cycle.
        for (int c = 0; c < 243; c++) begin
            if (c < 240) begin
                disp_req = 1'b1; disp_addr = 16'(c);
            end else begin
                disp_req = 1'b0;
            end
            if (c >= 3) begin
                chk($sformatf("stream_valid_%0d", c), disp_valid, 1);
                chk($sformatf("stream_data_%0d", c), disp_data, pat(c - 3));
            end
            chk($sformatf("stream_miss_%0d", c), disp_miss, 0);
            tick();
        end
        chk("stream_end_valid", disp_valid, 0);
        chk("stream_hold_data", disp_data, pat(239));

        // Starvation guard, CPU_WAIT_MAX=8: continuous display traffic.
        disp_req = 1'b1; disp_addr = 16'h0010;
        tick(); tick();
        cpu_txn(1'b0, 2'b00, 16'h0100, 16'h0000, 11, 1'b1, 16'h1234, "starve");
        chk("starve_miss_count", miss_cnt, 1);
        chk("starve_miss_cycle", miss_at, 9);
        chk("starve_cnt_cleared", 32'(dut.r_starve_cnt), 0);
        disp_req = 1'b0;
        tick(); tick(); tick(); tick();

        // CPU_WAIT_MAX=0: never forced while the display requests.
        disp_req0 = 1'b1; disp_addr = 16'h0030;
        cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_req0 = 1'b1;
        acks = 0; miss_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ack0) acks++;
            if (disp_miss0) miss_cnt++;
        end
        chk("nf_no_ack", acks, 0);
        chk("nf_no_miss", miss_cnt, 0);
        chk("nf_display_addr", mem_addr0, 16'h0030);
        disp_req0 = 1'b0;
        lat = 0;
        while (cpu_ack0 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("nf_latency", lat, 3);
        chk("nf_rdata", cpu_rdata0, pat(16'h0020));
        cpu_req0 = 1'b0;
        tick();

        // Byte-enable write merging.
        cpu_txn(1'b1, 2'b11, 16'h0200, 16'h5555, 3, 1'b0, 16'h0, "bw_full");
        cpu_txn(1'b1, 2'b10, 16'h0200, 16'hAB00, 3, 1'b0, 16'h0, "bw_hi");
        chk("bw_hi_be", be_seen, 2'b10);
        chk("bw_rdata_unchanged", cpu_rdata, 16'h1234);
        cpu_txn(1'b0, 2'b00, 16'h0200, 16'h0000, 3, 1'b1, 16'hAB55, "bw_rd");

        // Reset during C_RD of a CPU read.
        cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_req = 1'b1;
        tick(); tick();
        #1 rst = 1'b1;
        #1 chk_zero("midrst");
        cpu_req = 1'b0;
        tick();
        chk("midrst_ack_a", cpu_ack, 0);
        tick();
        chk("midrst_ack_b", cpu_ack, 0);
        rst = 1'b0;
        tick();
        chk("postrst_ack", cpu_ack, 0);
        cpu_txn(1'b0, 2'b00, 16'h0100, 16'h0000, 3, 1'b1, 16'h1234, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous VRAM between the display scan-out fetch and the CPU bus.
- Display has priority; the CPU is served in free cycles.
- A bounded starvation guard forces a CPU slot after a parameterised number of denied cycles.
- Sits between the CPU memory bus, the graphic scan-out path and the VRAM macro.

Parameters:
ADDR_W, 16, VRAM halfword address width
DATA_W, 16, VRAM data width
CPU_WAIT_MAX, 8, consecutive denied CPU cycles before a forced CPU slot; 0 = never force

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
disp_req  input  1  display wants the halfword at disp_addr this cycle
disp_addr  input  ADDR_W  display fetch address
disp_data  output  DATA_W  fetched display halfword (registered)
disp_valid  output  1  disp_data updated this cycle
disp_miss  output  1  pulse: display request denied by a forced CPU slot
cpu_req  input  1  CPU transaction pending; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_be  input  2  byte enables for writes ([1] = bits 15:8)
cpu_addr  input  ADDR_W  CPU halfword address
cpu_wdata  input  DATA_W  CPU write data
cpu_ack  output  1  one-cycle pulse: transaction complete
cpu_rdata  output  DATA_W  read data, valid with cpu_ack and held afterwards
mem_addr  output  ADDR_W  VRAM address (registered)
mem_we  output  1  VRAM write strobe (registered)
mem_be  output  2  VRAM byte enables (registered)
mem_wdata  output  DATA_W  VRAM write data (registered)
mem_rdata  input  DATA_W  VRAM read data, valid one cycle after mem_addr

Behaviour:
- Reset (async, immediate):
  - All outputs go to 0.
  - CPU FSM goes to C_IDLE and the starvation counter goes to 0.
  - An in-flight CPU transaction is dropped with no cpu_ack.
  - mem_we falls immediately.
- Arbitration at each rising edge:
  - CPU is eligible only in C_IDLE or C_WAIT with cpu_req=1.
  - Grant goes to the CPU if eligible and (disp_req=0, or CPU_WAIT_MAX!=0 and starve_cnt==CPU_WAIT_MAX).
  - Otherwise the grant goes to the display if disp_req=1.
  - Otherwise there is no grant: mem_addr holds and mem_we=0.
- Pipeline, grant decided at edge ending cycle N:
  - N+1: mem_* carry the winner's access.
  - N+2: mem_rdata valid.
  - N+3: registered results out.
  - Fixed latency is 3 cycles for both requesters.
- Display path:
  - A display grant at N gives disp_valid=1 in N+3 with disp_data = mem_rdata captured at the end of N+2.
  - disp_data holds between updates.
  - Fully pipelined: one display access per cycle sustained.
- Forced CPU slot with disp_req=1:
  - disp_miss pulses in N+1.
  - No disp_valid for that request (display reuses its previous pixel).
  - starve_cnt clears to 0.
- starve_cnt:
  - Increments, saturating at CPU_WAIT_MAX, each edge where the CPU is eligible but the display wins.
  - Clears on any CPU grant.
  - Holds while no CPU request is pending.
- CPU FSM states and transitions:
  - C_IDLE -> C_MEM on grant; C_IDLE -> C_WAIT if cpu_req and no grant.
  - C_WAIT -> C_MEM on grant.
  - C_MEM (mem cycle; mem_we=cpu_we, mem_be=cpu_be for writes, mem_be=2'b11 for reads) -> C_RD.
  - C_RD (mem_rdata sampled into cpu_rdata; write data unchanged) -> C_ACK.
  - C_ACK: cpu_ack=1 for one cycle -> C_IDLE.
- CPU handshake rules:
  - cpu_req, cpu_we, cpu_be, cpu_addr and cpu_wdata stay stable from assertion until cpu_ack.
  - cpu_req is ignored in C_MEM, C_RD and C_ACK.
  - A request still high in the cycle after cpu_ack is a new transaction.
  - One CPU transaction outstanding at most.
  - On a write, cpu_rdata is unchanged.
- Simultaneous access:
  - Display and CPU never share a mem cycle.
  - A display read of an address written by the CPU in the same or an earlier mem cycle returns the RAM's read-during-write value; the arbiter adds no forwarding.
- Width: addresses pass through unmodified; no address arithmetic inside the block.

Test Plan:
- Idle display, CPU write 0x1234 to 0x0100 with be=11, then read 0x0100: mem_we=1 one cycle; each cpu_ack arrives 3 cycles after cpu_req; cpu_rdata=0x1234.
- Display streams 0x0000..0x00EF every cycle, no CPU: disp_valid continuous from cycle 3; disp_data sequence matches the preloaded RAM; disp_miss never set.
- CPU read pending during continuous disp_req, CPU_WAIT_MAX=8: grant after exactly 8 denied cycles; one disp_miss pulse; cpu_ack 3 cycles after the grant; starve_cnt back to 0.
- Same stimulus with CPU_WAIT_MAX=0: CPU never granted while disp_req=1; drop disp_req -> grant next edge; ack 3 cycles later.
- Byte write be=10 of 0xAB00 over 0x5555: subsequent read returns 0xAB55.
- Assert rst in C_RD of a CPU read: no cpu_ack, all outputs 0 immediately; after release, a new read completes normally.
